// File: rtl/feeder_pkg.sv
// feeder_pkg: shared state type and default sizing for the operand_feeder slice.
package feeder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUT  = 2'd1,
    GAP  = 2'd2
  } feeder_state_t;

  localparam int FEEDER_DEPTH = 4;
  localparam int FEEDER_WIDTH = 8;
  localparam int FEEDER_FRAME = 3;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int bits_for(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/feeder_fifo.sv
// feeder_fifo: synchronous FIFO with occupancy count and a one-entry lookahead
// (head_next) so the feeder can register the next value while popping.
module feeder_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [WIDTH-1:0]           head_next,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;

  assign rd_ptr_inc = rd_ptr + PTR_W'(1);
  assign head       = mem[rd_ptr];
  assign head_next  = mem[rd_ptr_inc];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/operand_feeder.sv
// operand_feeder: buffers datapath bytes and replays them as unbroken put bursts
// of up to FRAME bytes, each closed by one gap cycle. Optional statistics
// counters are enabled with the OPERAND_FEEDER_STATS_EN macro.
module operand_feeder
  import feeder_pkg::*;
#(
  parameter int DEPTH = FEEDER_DEPTH,
  parameter int WIDTH = FEEDER_WIDTH,
  parameter int FRAME = FEEDER_FRAME
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             put_flag,
  output logic [WIDTH-1:0] value,
  output logic             frame_end,
  output logic             busy
`ifdef OPERAND_FEEDER_STATS_EN
  ,
  output logic [15:0]      frame_count,
  output logic [7:0]       flush_count
`endif
);

  localparam int LEN_W = bits_for(FRAME);
  localparam int CNT_W = bits_for(DEPTH);

  feeder_state_t    state;
  feeder_state_t    state_next;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_next;
  logic [LEN_W-1:0] slot;
  logic [LEN_W-1:0] slot_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] head_next;
  logic             push;
  logic             pop;
  logic             frame_ready;
  logic             flush_ready;

  assign in_ready    = (count < CNT_W'(DEPTH));
  assign push        = in_valid && in_ready;
  assign busy        = (state != IDLE) || (count != '0);
  assign frame_ready = (count >= CNT_W'(FRAME));
  assign flush_ready = flush && (count != '0);

  feeder_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .wr_data  (in_data),
    .pop      (pop),
    .head     (head),
    .head_next(head_next),
    .count    (count)
  );

  // A burst only starts once its whole length is already buffered, so PUT
  // can pop every cycle without checking the FIFO again.
  always_comb begin
    state_next = state;
    len_next   = len;
    slot_next  = slot;
    pop        = 1'b0;
    unique case (state)
      IDLE, GAP: begin
        slot_next = '0;
        if (frame_ready) begin
          len_next   = LEN_W'(FRAME);
          state_next = PUT;
        end else if (flush_ready) begin
          len_next   = LEN_W'(count);
          state_next = PUT;
        end else begin
          state_next = IDLE;
        end
      end
      PUT: begin
        pop       = 1'b1;
        slot_next = slot + LEN_W'(1);
        if (slot_next == len) begin
          state_next = GAP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state; value uses the lookahead
  // entry when the current cycle is also popping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      len       <= '0;
      slot      <= '0;
      put_flag  <= 1'b0;
      frame_end <= 1'b0;
      value     <= '0;
    end else begin
      state     <= state_next;
      len       <= len_next;
      slot      <= slot_next;
      put_flag  <= (state_next == PUT);
      frame_end <= (state_next == GAP);
      value     <= (state_next == PUT) ? (pop ? head_next : head) : '0;
    end
  end

`ifdef OPERAND_FEEDER_STATS_EN
  // len still describes the frame just closed while in GAP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
      flush_count <= '0;
    end else if (state == GAP) begin
      frame_count <= frame_count + 16'd1;
      if ((len < LEN_W'(FRAME)) && (flush_count != 8'hFF)) begin
        flush_count <= flush_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_operand_feeder.sv
// tb_operand_feeder: directed scenarios plus a randomized run checked against a
// byte-queue reference of the feeder's framing rules.
module tb_operand_feeder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       flush;
  logic       put_flag;
  logic [7:0] value;
  logic       frame_end;
  logic       busy;
`ifdef OPERAND_FEEDER_STATS_EN
  logic [15:0] frame_count;
  logic [7:0]  flush_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  operand_feeder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .put_flag   (put_flag),
    .value      (value),
    .frame_end  (frame_end),
    .busy       (busy)
`ifdef OPERAND_FEEDER_STATS_EN
    ,
    .frame_count(frame_count),
    .flush_count(flush_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    in_data  = 8'h00;
    reset_n  = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    in_data  = 8'h00;
    reset_n  = 1'b0;
    #3;
    total++; if (put_flag !== 1'b0) begin bad++; $display("[TB] FAIL reset_put_flag got %b want 0", put_flag); end
    total++; if (value !== 8'h00) begin bad++; $display("[TB] FAIL reset_value got %h want 00", value); end
    total++; if (frame_end !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_end got %b want 0", frame_end); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef OPERAND_FEEDER_STATS_EN
    total++; if (frame_count !== 16'h0) begin bad++; $display("[TB] FAIL reset_frame_count got %h want 0", frame_count); end
    total++; if (flush_count !== 8'h0) begin bad++; $display("[TB] FAIL reset_flush_count got %h want 0", flush_count); end
`endif
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_full_frame();
    logic [7:0] b [3];
    b = '{8'h11, 8'h22, 8'h33};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = b[k];
      tick();
    end
    in_valid = 1'b0;
    total++; if (put_flag !== 1'b0) begin bad++; $display("[TB] FAIL full_decide put_flag got %b want 0", put_flag); end
    tick();
    for (int k = 0; k < 3; k++) begin
      total++; if (put_flag !== 1'b1 || value !== b[k]) begin
        bad++; $display("[TB] FAIL full_put%0d got flag=%b value=%h want flag=1 value=%h", k, put_flag, value, b[k]);
      end
      tick();
    end
    total++; if (frame_end !== 1'b1 || put_flag !== 1'b0 || value !== 8'h00) begin
      bad++; $display("[TB] FAIL full_gap got end=%b flag=%b value=%h want end=1 flag=0 value=00", frame_end, put_flag, value);
    end
    tick();
    total++; if (frame_end !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL full_after got end=%b busy=%b want end=0 busy=0", frame_end, busy);
    end
  endtask

  task automatic test_streaming();
    int acc = 0;
    int puts = 0;
    int put_cyc[$];
    int gap_cyc[$];
    logic [7:0] got[$];
    bit saw_full = 0;
    do_reset();
    for (int cyc = 0; cyc < 30; cyc++) begin
      total++; if (in_ready !== ((acc - puts) < 4)) begin
        bad++; $display("[TB] FAIL stream_in_ready cyc=%0d got %b want %b", cyc, in_ready, ((acc - puts) < 4));
      end
      if ((acc - puts) == 4 && in_ready === 1'b0) saw_full = 1;
      if (put_flag === 1'b1) begin
        got.push_back(value);
        put_cyc.push_back(cyc);
        puts++;
      end
      if (frame_end === 1'b1) gap_cyc.push_back(cyc);
      if (acc < 6) begin
        in_valid = 1'b1;
        in_data  = 8'(acc + 1);
        if (in_ready) acc++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    total++; if (got.size() != 6 || gap_cyc.size() != 2) begin
      bad++; $display("[TB] FAIL stream_counts got puts=%0d gaps=%0d want puts=6 gaps=2", got.size(), gap_cyc.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++; if (got[i] !== 8'(i + 1)) begin bad++; $display("[TB] FAIL stream_value%0d got %h want %h", i, got[i], 8'(i + 1)); end
      end
      total++; if (put_cyc[2] - put_cyc[0] != 2 || put_cyc[5] - put_cyc[3] != 2) begin
        bad++; $display("[TB] FAIL stream_stall got spans %0d,%0d want 2,2", put_cyc[2] - put_cyc[0], put_cyc[5] - put_cyc[3]);
      end
      total++; if (gap_cyc[0] != put_cyc[2] + 1 || put_cyc[3] != gap_cyc[0] + 1 || gap_cyc[1] != put_cyc[5] + 1) begin
        bad++; $display("[TB] FAIL stream_gap got gap0=%0d put3=%0d gap1=%0d want single gaps after cycles %0d,%0d",
                        gap_cyc[0], put_cyc[3], gap_cyc[1], put_cyc[2], put_cyc[5]);
      end
    end
    total++; if (!saw_full) begin bad++; $display("[TB] FAIL stream_full got no in_ready drop want drop at count 4"); end
  endtask

  task automatic test_flush_partial();
    int n = 0;
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    repeat (5) begin
      if (put_flag === 1'b1 || frame_end === 1'b1) n++;
      tick();
    end
    total++; if (n != 0) begin bad++; $display("[TB] FAIL flush_wait got %0d active cycles want 0", n); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (put_flag !== 1'b1 || value !== 8'hA5) begin bad++; $display("[TB] FAIL flush_put0 got flag=%b value=%h want 1 a5", put_flag, value); end
    tick();
    total++; if (put_flag !== 1'b1 || value !== 8'h5A) begin bad++; $display("[TB] FAIL flush_put1 got flag=%b value=%h want 1 5a", put_flag, value); end
    tick();
    total++; if (frame_end !== 1'b1 || put_flag !== 1'b0 || value !== 8'h00) begin
      bad++; $display("[TB] FAIL flush_gap got end=%b flag=%b value=%h want 1 0 00", frame_end, put_flag, value);
    end
    tick();
    total++; if (put_flag !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL flush_after got flag=%b busy=%b want 0 0", put_flag, busy); end
`ifdef OPERAND_FEEDER_STATS_EN
    total++; if (flush_count !== 8'd1 || frame_count !== 16'd1) begin
      bad++; $display("[TB] FAIL flush_stats got flush=%0d frames=%0d want 1 1", flush_count, frame_count);
    end
`endif
  endtask

  task automatic test_flush_ignored();
    int n = 0;
    do_reset();
    flush = 1'b1;
    repeat (4) begin
      if (put_flag === 1'b1 || frame_end === 1'b1 || busy === 1'b1) n++;
      tick();
    end
    flush = 1'b0;
    total++; if (n != 0) begin bad++; $display("[TB] FAIL flush_empty got %0d active cycles want 0", n); end
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h41 + k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    total++; if (put_flag !== 1'b1) begin bad++; $display("[TB] FAIL flush_put_start got %b want 1", put_flag); end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h44;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b0;
    tick();
    total++; if (frame_end !== 1'b1) begin bad++; $display("[TB] FAIL flush_put_gap got %b want 1", frame_end); end
    tick();
    n = 0;
    repeat (8) begin
      if (put_flag === 1'b1 || frame_end === 1'b1) n++;
      tick();
    end
    total++; if (n != 0) begin bad++; $display("[TB] FAIL flush_during_put got %0d active cycles want 0", n); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL flush_held_busy got %b want 1", busy); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h71 + k);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    total++; if (put_flag !== 1'b1 || value !== 8'h72) begin bad++; $display("[TB] FAIL mid_put1 got flag=%b value=%h want 1 72", put_flag, value); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (put_flag !== 1'b0 || value !== 8'h00) begin bad++; $display("[TB] FAIL mid_async got flag=%b value=%h want 0 00", put_flag, value); end
    total++; if (in_ready !== 1'b1 || busy !== 1'b0 || frame_end !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_state got ready=%b busy=%b end=%b want 1 0 0", in_ready, busy, frame_end);
    end
    tick();
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h81 + k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++; if (put_flag !== 1'b1 || value !== 8'(8'h81 + k)) begin
        bad++; $display("[TB] FAIL mid_clean%0d got flag=%b value=%h want 1 %h", k, put_flag, value, 8'(8'h81 + k));
      end
      tick();
    end
    total++; if (frame_end !== 1'b1 || put_flag !== 1'b0) begin bad++; $display("[TB] FAIL mid_clean_gap got end=%b flag=%b want 1 0", frame_end, put_flag); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    bit prev_put = 0;
    bit start_flush = 0;
    int flen = 0;
    int frames = 0;
    int partials = 0;
    do_reset();
    for (int cyc = 0; cyc < 700; cyc++) begin
      total++; if (in_ready !== (exp_q.size() < 4)) begin
        bad++; $display("[TB] FAIL rand_in_ready cyc=%0d got %b want %b", cyc, in_ready, (exp_q.size() < 4));
      end
      if (put_flag === 1'b1) begin
        if (!prev_put) begin
          flen = 0;
          start_flush = flush;
        end
        flen++;
        total++; if (exp_q.size() == 0) begin
          bad++; $display("[TB] FAIL rand_put cyc=%0d got value %h want no put", cyc, value);
        end else begin
          d = exp_q.pop_front();
          if (value !== d) begin bad++; $display("[TB] FAIL rand_value cyc=%0d got %h want %h", cyc, value, d); end
        end
        total++; if (flen > 3 || frame_end !== 1'b0) begin
          bad++; $display("[TB] FAIL rand_burst cyc=%0d got len=%0d end=%b want len<=3 end=0", cyc, flen, frame_end);
        end
      end else if (frame_end === 1'b1) begin
        total++; if (!prev_put || value !== 8'h00) begin
          bad++; $display("[TB] FAIL rand_gap cyc=%0d got prev_put=%b value=%h want 1 00", cyc, prev_put, value);
        end
        total++; if (!(flen == 3 || (start_flush && flen >= 1))) begin
          bad++; $display("[TB] FAIL rand_len cyc=%0d got len=%0d flush=%b want 3 or flushed partial", cyc, flen, start_flush);
        end
        frames++;
        if (flen < 3) partials++;
      end else begin
        total++; if (prev_put) begin bad++; $display("[TB] FAIL rand_stall cyc=%0d got idle cycle want put or gap", cyc); end
      end
      prev_put = (put_flag === 1'b1);
      if (cyc < 600) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_data  = 8'($urandom);
        flush    = ($urandom_range(0, 19) == 0);
      end else begin
        in_valid = 1'b0;
        flush    = 1'b1;
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
      tick();
    end
    flush = 1'b0;
    total++; if (exp_q.size() != 0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL rand_drain got left=%0d busy=%b want 0 0", exp_q.size(), busy);
    end
`ifdef OPERAND_FEEDER_STATS_EN
    total++; if (frame_count !== 16'(frames) || flush_count !== 8'((partials > 255) ? 255 : partials)) begin
      bad++; $display("[TB] FAIL rand_stats got frames=%0d flushes=%0d want %0d %0d", frame_count, flush_count, frames, partials);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_streaming();
    test_flush_partial();
    test_flush_ignored();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
